// File: rtl/cbus_mem_responder.sv
// Memory-side cache-bus responder: a MEM_WORDS x 64-bit RAM at BASE_ADDR that answers one
// request at a time with len+1 beats after a programmable latency.
module cbus_mem_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic         clk,
    input  logic         reset,
    // ireq  = {valid, is_write, size[2:0], addr[63:0], strobe[7:0], data[63:0], len[7:0], burst[1:0]}
    input  logic [150:0] ireq,
    // oresp = {ready, last, data[63:0]}
    output logic [65:0]  oresp,
    output logic         oob_err
);
    localparam int         IDX_W    = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_BEAT = 2'd2;

    logic             w_valid;
    logic             w_is_write;
    logic [63:0]      w_addr;
    logic [7:0]       w_strobe;
    logic [63:0]      w_data;
    logic [7:0]       w_len;
    logic [1:0]       w_burst;
    logic             w_unused_bits;

    assign w_valid       = ireq[150];
    assign w_is_write    = ireq[149];
    assign w_addr        = ireq[145:82];
    assign w_strobe      = ireq[81:74];
    assign w_data        = ireq[73:10];
    assign w_len         = ireq[9:2];
    assign w_burst       = ireq[1:0];
    assign w_unused_bits = ^{ireq[148:146], w_addr[2:0]};

    logic [1:0]       r_state;
    logic [3:0]       r_lat_cnt;
    logic [7:0]       r_beats_left;
    logic [IDX_W-1:0] r_idx;
    logic             r_is_write;
    logic             r_fixed;
    logic             r_oob;
    logic             r_oob_err;
    logic [63:0]      r_rdata;
    logic [63:0]      r_mem [MEM_WORDS];

    logic             w_accept;
    logic             w_beat;
    logic             w_last;
    logic             w_in_oob;
    logic [IDX_W-1:0] w_idx_nxt;

    assign w_accept = (r_state == S_IDLE) && w_valid;
    // A dropped valid suppresses the beat in the same cycle, so nothing is presented or written.
    assign w_beat   = (r_state == S_BEAT) && w_valid;
    assign w_last   = w_beat && (r_beats_left == 8'd0);
    // BASE_ADDR is aligned to the window size, so the window test is a compare of the upper bits.
    assign w_in_oob = (w_addr[63:IDX_W+3] != BASE_ADDR[63:IDX_W+3]);

    // Index of the beat served next cycle; the RAM read is issued with it one cycle early.
    always_comb begin
        w_idx_nxt = r_idx;
        if (w_accept) begin
            w_idx_nxt = w_addr[IDX_W+2:3];
        end else if (w_beat && !w_last && !r_fixed) begin
            w_idx_nxt = r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lat_cnt    <= 4'd0;
            r_beats_left <= 8'd0;
            r_idx        <= '0;
            r_is_write   <= 1'b0;
            r_fixed      <= 1'b0;
            r_oob        <= 1'b0;
            r_oob_err    <= 1'b0;
        end else begin
            r_oob_err <= w_accept && w_in_oob;
            r_idx     <= w_idx_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_valid) begin
                        r_is_write   <= w_is_write;
                        r_fixed      <= (w_burst == 2'b00);
                        r_oob        <= w_in_oob;
                        r_lat_cnt    <= LAT_INIT;
                        r_beats_left <= w_len;
                        r_state      <= (LATENCY == 0) ? S_BEAT : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!w_valid) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                        if (r_lat_cnt <= 4'd1) begin
                            r_state <= S_BEAT;
                        end
                    end
                end
                S_BEAT: begin
                    if (!w_valid || (r_beats_left == 8'd0)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_beats_left <= r_beats_left - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM contents survive reset; this block is kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        r_rdata <= r_mem[w_idx_nxt];
        if (w_beat && r_is_write && !r_oob) begin
            for (int k = 0; k < 8; k++) begin
                if (w_strobe[k]) begin
                    r_mem[r_idx][8*k +: 8] <= w_data[8*k +: 8];
                end
            end
        end
    end

    assign oresp   = {w_beat, w_last,
                      (w_beat && !r_is_write && !r_oob) ? r_rdata : 64'd0};
    assign oob_err = r_oob_err;

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Bench for cbus_mem_responder: directed scenarios plus randomized transactions, checked
// cycle by cycle against a word-array memory model and the protocol timing rules.
module tb_cbus_mem_responder;
    localparam int          MEM_WORDS = 4096;
    localparam int          LATENCY   = 2;
    localparam logic [63:0] BASE      = 64'h8000_0000;

    logic         clk;
    logic         reset;
    logic [150:0] ireq;
    logic [65:0]  oresp;
    logic         oob_err;

    logic         q_valid;
    logic         q_wr;
    logic [2:0]   q_size;
    logic [63:0]  q_addr;
    logic [7:0]   q_strb;
    logic [63:0]  q_data;
    logic [7:0]   q_len;
    logic [1:0]   q_burst;

    assign ireq = {q_valid, q_wr, q_size, q_addr, q_strb, q_data, q_len, q_burst};

    cbus_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .LATENCY  (LATENCY),
        .BASE_ADDR(BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ireq   (ireq),
        .oresp  (oresp),
        .oob_err(oob_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [63:0] model_mem [MEM_WORDS];
    logic [63:0] wdata [256];
    logic [7:0]  wstrb [256];
    logic [63:0] rd_got [256];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    function automatic bit is_oob(input logic [63:0] a);
        return (a < BASE) || (a >= BASE + 64'(MEM_WORDS) * 64'd8);
    endfunction

    function automatic int word_of(input logic [63:0] a);
        return int'(((a - BASE) / 64'd8) % 64'(MEM_WORDS));
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    // drop_after > 0 drops valid once that many beats have completed.
    task automatic run_txn(input bit wr, input logic [63:0] addr, input int len,
                           input logic [1:0] burst, input int drop_after);
        logic [63:0] cur;
        logic [63:0] exp_data;
        bit          oob;
        bit          aborted;
        int          idx;
        oob     = is_oob(addr);
        cur     = addr;
        aborted = 0;
        q_valid = 1'b1;
        q_wr    = wr;
        q_size  = 3'($urandom_range(0, 7));
        q_addr  = addr;
        q_len   = 8'(len);
        q_burst = burst;
        q_data  = wdata[0];
        q_strb  = wstrb[0];
        @(posedge clk);
        @(negedge clk);
        chk("oob_err_pulse", 128'(oob_err), 128'(oob));
        for (int c = 0; c < LATENCY; c++) begin
            chk("latency_idle", 128'(oresp), 128'd0);
            @(negedge clk);
        end
        for (int b = 0; b <= len; b++) begin
            idx      = word_of(cur);
            exp_data = (wr || oob) ? 64'd0 : model_mem[idx];
            chk("beat", 128'(oresp), 128'({1'b1, (b == len), exp_data}));
            rd_got[b] = oresp[63:0];
            q_data = wdata[b];
            q_strb = wstrb[b];
            if (wr && !oob) begin
                for (int k = 0; k < 8; k++) begin
                    if (wstrb[b][k]) model_mem[idx][8*k +: 8] = wdata[b][8*k +: 8];
                end
            end
            if (burst != 2'b00) cur = cur + 64'd8;
            if ((b + 1 == drop_after) && (b < len)) begin
                @(posedge clk);
                #1;
                q_valid = 1'b0;
                @(negedge clk);
                chk("abort_no_ready", 128'(oresp), 128'd0);
                @(negedge clk);
                chk("abort_idle", 128'(oresp), 128'd0);
                aborted = 1;
                break;
            end
            @(negedge clk);
        end
        if (!aborted) begin
            chk("after_last", 128'(oresp), 128'd0);
            chk("oob_err_once", 128'(oob_err), 128'd0);
            q_valid = 1'b0;
        end
    endtask

    initial begin
        logic [63:0] a;
        int          ln;
        int          drop;
        logic [1:0]  bu;
        bit          w;

        q_valid = 1'b0; q_wr = 1'b0; q_size = 3'd0; q_addr = 64'd0;
        q_strb  = 8'd0; q_data = 64'd0; q_len = 8'd0; q_burst = 2'd0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_oresp", 128'(oresp), 128'd0);
        chk("reset_oob_err", 128'(oob_err), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Fill the whole RAM so every later read has a known expected value.
        for (int t = 0; t < MEM_WORDS / 256; t++) begin
            for (int i = 0; i < 256; i++) begin
                wdata[i] = {$urandom, $urandom};
                wstrb[i] = 8'hFF;
            end
            run_txn(1, BASE + 64'(t) * 64'd2048, 255, 2'b01, 0);
        end

        // Single-beat read with latency 2.
        wdata[0] = 64'hDEAD_BEEF_0123_4567; wstrb[0] = 8'hFF;
        run_txn(1, 64'h8000_0010, 0, 2'b01, 0);
        run_txn(0, 64'h8000_0010, 0, 2'b01, 0);
        chk("t1_data", 128'(rd_got[0]), 128'(64'hDEAD_BEEF_0123_4567));

        // Four-beat INCR write then read back.
        for (int i = 0; i < 4; i++) begin
            wdata[i] = 64'(i + 1);
            wstrb[i] = 8'hFF;
        end
        run_txn(1, 64'h8000_0000, 3, 2'b01, 0);
        run_txn(0, 64'h8000_0000, 3, 2'b01, 0);
        for (int i = 0; i < 4; i++) chk("t2_data", 128'(rd_got[i]), 128'(i + 1));

        // Partial strobe write.
        wdata[0] = 64'd0; wstrb[0] = 8'hFF;
        run_txn(1, 64'h8000_0040, 0, 2'b01, 0);
        wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb[0] = 8'h0F;
        run_txn(1, 64'h8000_0040, 0, 2'b01, 0);
        run_txn(0, 64'h8000_0040, 0, 2'b01, 0);
        chk("t3_strobe", 128'(rd_got[0]), 128'(64'h0000_0000_FFFF_FFFF));

        // Wrap from the last word to word 0, then a FIXED burst.
        run_txn(0, BASE + 64'(MEM_WORDS - 1) * 64'd8, 1, 2'b01, 0);
        chk("t4_wrap", 128'(rd_got[1]), 128'(64'd1));
        run_txn(0, 64'h8000_0018, 2, 2'b00, 0);
        chk("t4_fixed_a", 128'(rd_got[1]), 128'(rd_got[0]));
        chk("t4_fixed_b", 128'(rd_got[2]), 128'(64'd4));

        // Out-of-window read and write.
        run_txn(0, 64'h0000_1000, 0, 2'b01, 0);
        chk("t5_oob_data", 128'(rd_got[0]), 128'd0);
        wdata[0] = 64'h1234_5678_9ABC_DEF0; wstrb[0] = 8'hFF;
        run_txn(1, 64'h0000_1000, 0, 2'b01, 0);
        run_txn(0, BASE + 64'h1000, 0, 2'b01, 0);

        // Valid dropped after the first beat, then a normal request.
        run_txn(0, 64'h8000_0000, 3, 2'b01, 1);
        run_txn(0, 64'h8000_0000, 3, 2'b01, 0);
        chk("t6_after_abort", 128'(rd_got[3]), 128'(64'd4));

        // Reset in the middle of the latency wait.
        q_valid = 1'b1; q_wr = 1'b0; q_addr = 64'h8000_0008; q_len = 8'd3; q_burst = 2'b01;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_reset_resp", 128'(oresp), 128'd0);
        @(negedge clk);
        chk("t6_reset_hold", 128'(oresp), 128'd0);
        q_valid = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_reset_idle", 128'(oresp), 128'd0);
        end
        run_txn(0, 64'h8000_0008, 3, 2'b01, 0);
        chk("t6_resume", 128'(rd_got[0]), 128'(64'd2));

        // Randomized mix of reads, writes, bursts, out-of-window and aborted transfers.
        for (int t = 0; t < 80; t++) begin
            w  = 1'($urandom_range(0, 1));
            ln = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 4);
            bu = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = 64'($urandom_range(0, 32'h7FFF_FFF8));
                1:       a = BASE + 64'(MEM_WORDS) * 64'd8 + 64'($urandom_range(0, 4096));
                default: a = BASE + 64'($urandom_range(0, MEM_WORDS * 8 - 1));
            endcase
            drop = (ln > 0 && $urandom_range(0, 5) == 0) ? $urandom_range(1, ln) : 0;
            for (int i = 0; i <= ln; i++) begin
                wdata[i] = {$urandom, $urandom};
                wstrb[i] = 8'($urandom);
            end
            run_txn(w, a, ln, bu, drop);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
